// File: rtl/i2c_poll_if.sv
// ----------------------------------------------------------------------------
// i2c_poll_if
// Handshake bundle between the periodic poller and a byte-oriented I2C master.
//   m_din     : write payload, byte BYTES_W-1 is sent first
//   m_ain     : 7-bit slave address in bits [6:0]
//   m_opcode  : 0 = write, 1 = read
//   m_ptr_set : write carries only the register pointer
//   m_vin     : one-cycle start strobe for the master
//   m_dout    : read payload returned by the master
//   m_vout    : m_dout valid qualifier
//   m_busy    : master is executing a transaction
// Modport master: the side that issues requests (the poller).
// Modport slave : the I2C master engine that serves them.
// ----------------------------------------------------------------------------
interface i2c_poll_if #(
    parameter int BYTES_W = 3,
    parameter int BYTES_R = 2
);
    logic [BYTES_W*8-1:0] m_din;
    logic [7:0]           m_ain;
    logic                 m_opcode;
    logic                 m_ptr_set;
    logic                 m_vin;
    logic [BYTES_R*8-1:0] m_dout;
    logic                 m_vout;
    logic                 m_busy;

    modport master (
        output m_din, m_ain, m_opcode, m_ptr_set, m_vin,
        input  m_dout, m_vout, m_busy
    );

    modport slave (
        input  m_din, m_ain, m_opcode, m_ptr_set, m_vin,
        output m_dout, m_vout, m_busy
    );
endinterface

// File: rtl/i2c_poll.sv
// ----------------------------------------------------------------------------
// i2c_poll
// Periodically reads one register of an I2C slave through an I2C master
// engine (pointer write followed by a read), and forwards configuration
// writes requested by the host in between polls.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : periodic polling allowed
//   cfg_v     : configuration write request (accepted when cfg_rdy=1)
//   cfg_data  : configuration write payload
//   cfg_rdy   : cfg_v is accepted this cycle
//   res_data  : last register value read
//   res_v     : one-cycle pulse, res_data updated
//   err       : one-cycle pulse on master handshake timeout
//   bus       : request/response handshake with the I2C master engine
// ----------------------------------------------------------------------------
module i2c_poll #(
    parameter int          PERIOD   = 1000000,
    parameter int          TIMEOUT  = 65535,
    parameter int          BYTES_W  = 3,
    parameter int          BYTES_R  = 2,
    parameter logic [7:0]  DEV_ADDR = 8'h48,
    parameter logic [7:0]  REG_PTR  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_v,
    input  logic [BYTES_W*8-1:0] cfg_data,
    output logic                 cfg_rdy,
    output logic [BYTES_R*8-1:0] res_data,
    output logic                 res_v,
    output logic                 err,
    i2c_poll_if.master           bus
);
    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    // Pointer-only write: register pointer in the first-sent byte lane.
    localparam logic [BYTES_W*8-1:0] PTR_WORD = {REG_PTR, {(BYTES_W-1)*8{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WAIT_TMR, PTR_START, PTR_WAIT, RD_START, RD_WAIT, CFG_START, CFG_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [BYTES_W*8-1:0] m_din_q, m_din_d;
    logic                 m_opcode_q, m_opcode_d;
    logic                 m_ptr_set_q, m_ptr_set_d;
    logic                 m_vin_q, m_vin_d;
    logic [BYTES_R*8-1:0] res_data_q, res_data_d;
    logic                 res_v_q, res_v_d;
    logic                 err_q, err_d;
    logic                 cfg_accept;
    logic                 to_hit;

    assign cfg_rdy    = ((state_q == IDLE) || (state_q == WAIT_TMR)) && !bus.m_busy;
    assign cfg_accept = cfg_v && cfg_rdy;
    assign to_hit     = (to_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;            // timer only survives while waiting in WAIT_TMR
        to_d        = '0;            // timeout counter restarts on every state change
        m_din_d     = m_din_q;
        m_opcode_d  = m_opcode_q;
        m_ptr_set_d = m_ptr_set_q;
        m_vin_d     = 1'b0;
        res_data_d  = res_data_q;
        res_v_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE, WAIT_TMR: begin
                if (cfg_accept) begin
                    // Config wins over a poll start falling in the same cycle.
                    m_din_d     = cfg_data;
                    m_opcode_d  = 1'b0;
                    m_ptr_set_d = 1'b0;
                    m_vin_d     = 1'b1;
                    state_d     = CFG_START;
                end else if (state_q == IDLE) begin
                    if (enable) state_d = WAIT_TMR;
                end else if (!enable) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    if (!bus.m_busy) begin
                        m_din_d     = PTR_WORD;
                        m_opcode_d  = 1'b0;
                        m_ptr_set_d = 1'b1;
                        m_vin_d     = 1'b1;
                        state_d     = PTR_START;
                    end else begin
                        timer_d = timer_q;   // hold off until the master is free
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PTR_START, RD_START, CFG_START: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus.m_busy) begin
                    state_d = (state_q == PTR_START) ? PTR_WAIT :
                              (state_q == RD_START)  ? RD_WAIT  : CFG_WAIT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            PTR_WAIT: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!bus.m_busy) begin
                    m_opcode_d  = 1'b1;
                    m_ptr_set_d = 1'b0;
                    m_vin_d     = 1'b1;
                    state_d     = RD_START;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            RD_WAIT, CFG_WAIT: begin
                if (to_hit) begin
                    // Timeout suppresses any capture so res_v and err never coincide.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    if ((state_q == RD_WAIT) && bus.m_vout) begin
                        res_data_d = bus.m_dout;
                        res_v_d    = 1'b1;
                    end
                    if (!bus.m_busy) begin
                        state_d = enable ? WAIT_TMR : IDLE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            to_q        <= '0;
            m_din_q     <= '0;
            m_opcode_q  <= 1'b0;
            m_ptr_set_q <= 1'b0;
            m_vin_q     <= 1'b0;
            res_data_q  <= '0;
            res_v_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            to_q        <= to_d;
            m_din_q     <= m_din_d;
            m_opcode_q  <= m_opcode_d;
            m_ptr_set_q <= m_ptr_set_d;
            m_vin_q     <= m_vin_d;
            res_data_q  <= res_data_d;
            res_v_q     <= res_v_d;
            err_q       <= err_d;
        end
    end

    assign bus.m_ain     = DEV_ADDR;
    assign bus.m_din     = m_din_q;
    assign bus.m_opcode  = m_opcode_q;
    assign bus.m_ptr_set = m_ptr_set_q;
    assign bus.m_vin     = m_vin_q;
    assign res_data      = res_data_q;
    assign res_v         = res_v_q;
    assign err           = err_q;
endmodule

// File: tb/tb_i2c_poll.sv
// ----------------------------------------------------------------------------
// tb_i2c_poll
// Self-checking bench for i2c_poll with a small behavioural I2C master model.
// Table of single transactions (polls and config writes), then hand-written
// sequences for collision, disable, timeout and mid-read reset.
// ----------------------------------------------------------------------------
module tb_i2c_poll;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 50;
    // Cycles from CFG m_vin to the next poll m_vin with the model below
    // (busy 5 cycles, one idle cycle of detection, then a full period).
    localparam int CFG_TO_POLL = PERIOD + 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_v = 1'b0;
    logic [23:0] cfg_data = '0;
    logic        cfg_rdy;
    logic [15:0] res_data;
    logic        res_v;
    logic        err;

    i2c_poll_if #(.BYTES_W(3), .BYTES_R(2)) bus ();

    i2c_poll #(
        .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .BYTES_W(3), .BYTES_R(2),
        .DEV_ADDR(8'h48), .REG_PTR(8'h05)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_v(cfg_v), .cfg_data(cfg_data),
        .cfg_rdy(cfg_rdy), .res_data(res_data), .res_v(res_v), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;

    typedef struct {
        logic [23:0] din;
        logic        op;
        logic        ptr;
        int          cyc;
    } txn_t;

    txn_t txq[$];
    int   resq[$];
    int   errq[$];

    logic [15:0] rd_val = '0;
    bit          dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.m_vin === 1'b1) txq.push_back('{bus.m_din, bus.m_opcode, bus.m_ptr_set, cyc});
        if (res_v === 1'b1) resq.push_back(cyc);
        if (err === 1'b1) errq.push_back(cyc);
        if (bus.m_vin === 1'b1 && bus.m_busy === 1'b1) viol++;
        if (res_v === 1'b1 && err === 1'b1) viol++;
    end

    // Behavioural I2C master: busy one cycle after m_vin, for 5 cycles on a
    // write, 6 on a read with m_vout in the fifth busy cycle.
    initial begin : master
        logic op;
        bus.m_busy = 1'b0;
        bus.m_vout = 1'b0;
        bus.m_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_vin === 1'b1 && !dead) begin
                op = bus.m_opcode;
                @(posedge clk); #1 bus.m_busy = 1'b1;
                repeat (4) begin @(posedge clk); #1; end
                if (op) begin
                    bus.m_dout = rd_val;
                    bus.m_vout = 1'b1;
                    @(posedge clk); #1 bus.m_vout = 1'b0;
                end
                @(posedge clk); #1 bus.m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_txn(input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) tick(1);
    endtask

    task automatic wait_res(input int n, input int budget);
        for (int i = 0; i < budget && resq.size() < n; i++) tick(1);
    endtask

    typedef struct {
        bit          is_cfg;
        logic [23:0] cfg;
        logic [15:0] rd;
        logic [23:0] exp_din;
        logic        exp_op;
        logic        exp_ptr;
        logic [15:0] exp_res;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        int   b, rb, eb, e, c;

        vecs[0] = '{1'b0, 24'h000000, 16'h1A2B, 24'h050000, 1'b0, 1'b1, 16'h1A2B};
        vecs[1] = '{1'b1, 24'h0160A0, 16'h0000, 24'h0160A0, 1'b0, 1'b0, 16'h1A2B};
        vecs[2] = '{1'b0, 24'h000000, 16'h0000, 24'h050000, 1'b0, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 24'hFFFFFF, 16'h0000, 24'hFFFFFF, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 24'h000000, 16'hFFFF, 24'h050000, 1'b0, 1'b1, 16'hFFFF};
        vecs[5] = '{1'b1, 24'h000001, 16'h0000, 24'h000001, 1'b0, 1'b0, 16'hFFFF};

        // ---- reset state ----
        tick(3);
        chk("rst_m_vin",    32'(bus.m_vin), 32'd0);
        chk("rst_m_din",    32'(bus.m_din), 32'd0);
        chk("rst_opcode",   32'(bus.m_opcode), 32'd0);
        chk("rst_ptr_set",  32'(bus.m_ptr_set), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_v",    32'(res_v), 32'd0);
        chk("rst_err",      32'(err), 32'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("m_ain",        32'(bus.m_ain), 32'h48);

        // ---- table of single transactions ----
        for (int v = 0; v < 6; v++) begin
            b  = txq.size();
            rb = resq.size();
            eb = errq.size();
            rd_val = vecs[v].rd;
            if (vecs[v].is_cfg) begin
                cfg_data = vecs[v].cfg;
                cfg_v = 1'b1;
                c = cyc;
                chk($sformatf("v%0d_cfg_rdy", v), 32'(cfg_rdy), 32'd1);
                tick(1);
                cfg_v = 1'b0;
                wait_txn(b + 1, 20);
                chk($sformatf("v%0d_txn_seen", v), 32'(txq.size() >= b + 1), 32'd1);
                if (txq.size() >= b + 1) begin
                    chk($sformatf("v%0d_din", v), 32'(txq[b].din), 32'(vecs[v].exp_din));
                    chk($sformatf("v%0d_op", v),  32'(txq[b].op),  32'(vecs[v].exp_op));
                    chk($sformatf("v%0d_ptr", v), 32'(txq[b].ptr), 32'(vecs[v].exp_ptr));
                    chk($sformatf("v%0d_lat", v), 32'(txq[b].cyc - c), 32'd1);
                end
                tick(20);
                chk($sformatf("v%0d_no_res_v", v), 32'(resq.size() - rb), 32'd0);
                chk($sformatf("v%0d_txn_cnt", v),  32'(txq.size() - b), 32'd1);
            end else begin
                enable = 1'b1;
                e = cyc;
                wait_txn(b + 2, 400);
                chk($sformatf("v%0d_txn_seen", v), 32'(txq.size() >= b + 2), 32'd1);
                if (txq.size() >= b + 2) begin
                    chk($sformatf("v%0d_ptr_din", v), 32'(txq[b].din), 32'(vecs[v].exp_din));
                    chk($sformatf("v%0d_ptr_op", v),  32'(txq[b].op),  32'(vecs[v].exp_op));
                    chk($sformatf("v%0d_ptr_set", v), 32'(txq[b].ptr), 32'(vecs[v].exp_ptr));
                    chk($sformatf("v%0d_poll_lat", v), 32'(txq[b].cyc - e), 32'(PERIOD + 1));
                    chk($sformatf("v%0d_rd_op", v),  32'(txq[b+1].op),  32'd1);
                    chk($sformatf("v%0d_rd_ptr", v), 32'(txq[b+1].ptr), 32'd0);
                end
                wait_res(rb + 1, 40);
                enable = 1'b0;
                tick(20);
                chk($sformatf("v%0d_res_v_cnt", v), 32'(resq.size() - rb), 32'd1);
            end
            chk($sformatf("v%0d_res_data", v), 32'(res_data), 32'(vecs[v].exp_res));
            chk($sformatf("v%0d_no_err", v),   32'(errq.size() - eb), 32'd0);
        end

        // ---- collision: cfg on the timer==PERIOD-1 cycle ----
        b  = txq.size();
        rb = resq.size();
        rd_val = 16'h5A5A;
        enable = 1'b1;
        e = cyc;
        tick(PERIOD);
        cfg_data = 24'h0160A0;
        cfg_v = 1'b1;
        chk("col_cfg_rdy", 32'(cfg_rdy), 32'd1);
        tick(1);
        cfg_v = 1'b0;
        wait_txn(b + 2, 300);
        chk("col_txn_seen", 32'(txq.size() >= b + 2), 32'd1);
        if (txq.size() >= b + 2) begin
            chk("col_first_ptr", 32'(txq[b].ptr), 32'd0);
            chk("col_first_din", 32'(txq[b].din), 32'h0160A0);
            chk("col_first_lat", 32'(txq[b].cyc - e), 32'(PERIOD + 1));
            chk("col_poll_ptr",  32'(txq[b+1].ptr), 32'd1);
            chk("col_poll_gap",  32'(txq[b+1].cyc - txq[b].cyc), 32'(CFG_TO_POLL));
        end
        wait_res(rb + 1, 40);
        enable = 1'b0;
        tick(20);
        chk("col_res_data", 32'(res_data), 32'h5A5A);

        // ---- disable during PTR_WAIT: read still completes ----
        b  = txq.size();
        rb = resq.size();
        rd_val = 16'hBEEF;
        enable = 1'b1;
        wait_txn(b + 1, 300);
        tick(2);
        enable = 1'b0;
        wait_txn(b + 2, 50);
        wait_res(rb + 1, 50);
        tick(150);
        chk("dis_txn_cnt",  32'(txq.size() - b), 32'd2);
        chk("dis_res_v",    32'(resq.size() - rb), 32'd1);
        chk("dis_res_data", 32'(res_data), 32'hBEEF);
        chk("dis_cfg_rdy",  32'(cfg_rdy), 32'd1);

        // ---- timeout: master never goes busy ----
        b  = txq.size();
        eb = errq.size();
        rb = resq.size();
        dead = 1'b1;
        cfg_data = 24'h123456;
        cfg_v = 1'b1;
        tick(1);
        cfg_v = 1'b0;
        for (int i = 0; i < 100 && errq.size() < eb + 1; i++) tick(1);
        chk("to_err_seen", 32'(errq.size() >= eb + 1), 32'd1);
        if (errq.size() >= eb + 1 && txq.size() >= b + 1)
            chk("to_err_lat", 32'(errq[eb] - txq[b].cyc), 32'(TIMEOUT));
        chk("to_idle_cfg_rdy", 32'(cfg_rdy), 32'd1);
        tick(20);
        chk("to_err_cnt",   32'(errq.size() - eb), 32'd1);
        chk("to_txn_cnt",   32'(txq.size() - b), 32'd1);
        chk("to_res_data",  32'(res_data), 32'hBEEF);
        chk("to_no_res_v",  32'(resq.size() - rb), 32'd0);
        dead = 1'b0;

        // ---- reset while in RD_WAIT ----
        b  = txq.size();
        rb = resq.size();
        rd_val = 16'h1234;
        enable = 1'b1;
        wait_txn(b + 2, 300);
        tick(1);
        rst = 1'b1;
        enable = 1'b0;
        tick(1);
        chk("rrst_m_vin",    32'(bus.m_vin), 32'd0);
        chk("rrst_m_din",    32'(bus.m_din), 32'd0);
        chk("rrst_opcode",   32'(bus.m_opcode), 32'd0);
        chk("rrst_res_data", 32'(res_data), 32'd0);
        chk("rrst_res_v",    32'(res_v), 32'd0);
        chk("rrst_busy_rdy", 32'(cfg_rdy), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(150);
        chk("rrst_no_txn",   32'(txq.size() - b), 32'd2);
        chk("rrst_no_res",   32'(resq.size() - rb), 32'd0);
        chk("rrst_res_hold", 32'(res_data), 32'd0);
        chk("rrst_cfg_rdy",  32'(cfg_rdy), 32'd1);
        b = txq.size();
        enable = 1'b1;
        e = cyc;
        wait_txn(b + 1, 300);
        chk("rrst_poll_seen", 32'(txq.size() >= b + 1), 32'd1);
        if (txq.size() >= b + 1) begin
            chk("rrst_poll_lat", 32'(txq[b].cyc - e), 32'(PERIOD + 1));
            chk("rrst_poll_ptr", 32'(txq[b].ptr), 32'd1);
        end
        wait_res(rb + 1, 60);
        enable = 1'b0;
        tick(20);
        chk("rrst_res_data2", 32'(res_data), 32'h1234);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_poll.md
I2C_POLL -- requirements
Module: i2c_poll

Interface
REQ-001 SHALL have parameter PERIOD, default 1000000: clocks between poll starts (>=2).
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum clocks to wait on any master handshake phase.
REQ-003 SHALL have parameter BYTES_W, default 3: write payload bytes of the I2C master (>=2).
REQ-004 SHALL have parameter BYTES_R, default 2: read payload bytes of the I2C master (>=1).
REQ-005 SHALL have parameter DEV_ADDR, default 8'h48: 7-bit slave address in bits [6:0].
REQ-006 SHALL have parameter REG_PTR, default 8'h00: register pointer polled.
REQ-007 SHALL have ports clk in 1 (clock) and rst in 1 (reset): rst is synchronous, active-high, clock is clk.
REQ-008 SHALL have port enable in 1: periodic polling allowed.
REQ-009 SHALL have port cfg_v in 1: configuration write request, one-cycle qualifier.
REQ-010 SHALL have port cfg_data in BYTES_W*8: write payload, byte BYTES_W-1 (MSB lane) sent first.
REQ-011 SHALL have port cfg_rdy out 1: cfg_v is accepted this cycle.
REQ-012 SHALL have port res_data out BYTES_R*8: last read result, master byte order preserved.
REQ-013 SHALL have port res_v out 1: one-cycle pulse, res_data updated.
REQ-014 SHALL have port err out 1: one-cycle pulse on handshake timeout.
REQ-015 SHALL have master-side ports m_din out BYTES_W*8, m_ain out 8, m_opcode out 1, m_ptr_set out 1, m_vin out 1, m_dout in BYTES_R*8, m_vout in 1, m_busy in 1.

Function
REQ-016 SHALL drive m_ain constantly to DEV_ADDR.
REQ-017 SHALL implement FSM states IDLE, WAIT_TMR, PTR_START, PTR_WAIT, RD_START, RD_WAIT, CFG_START, CFG_WAIT.
REQ-018 SHALL assert cfg_rdy combinationally only in IDLE or WAIT_TMR with m_busy=0.
REQ-019 SHALL, on cfg_v&&cfg_rdy, register m_din<=cfg_data, m_opcode<=0, m_ptr_set<=0, pulse m_vin one cycle, enter CFG_START.
REQ-020 SHALL, in IDLE, with enable=1 and no cfg accept, enter WAIT_TMR with timer cleared.
REQ-021 SHALL, in WAIT_TMR, increment timer each cycle; when timer==PERIOD-1, load m_din MSB byte with REG_PTR (other bytes 0), m_opcode<=0, m_ptr_set<=1, pulse m_vin, enter PTR_START.
REQ-022 SHALL give cfg accept priority over poll start when both occur in the same cycle; timer is cleared on cfg accept.
REQ-023 SHALL return WAIT_TMR to IDLE when enable=0; enable deassertion in other states SHALL NOT abort a transaction.
REQ-024 SHALL, in *_START states, wait for m_busy=1, then enter the matching *_WAIT state.
REQ-025 SHALL, in PTR_WAIT, on m_busy=0, set m_opcode<=1, m_ptr_set<=0, pulse m_vin, enter RD_START.
REQ-026 SHALL, in RD_WAIT, capture res_data<=m_dout on m_vout=1 and pulse res_v the following cycle.
REQ-027 SHALL, in RD_WAIT or CFG_WAIT, on m_busy=0, go to WAIT_TMR (enable=1) or IDLE (enable=0) with timer cleared.
REQ-028 SHALL clear the timeout counter on every state entry and, in any *_START/*_WAIT state, on count==TIMEOUT-1 pulse err, drop m_vin, go to IDLE; res_data unchanged.
REQ-029 SHALL NOT pulse m_vin in any cycle where m_busy=1.
REQ-030 SHALL never assert res_v and err in the same cycle; m_vout outside RD_WAIT is ignored.
REQ-031 SHALL size timer to clog2(PERIOD) bits and the timeout counter to clog2(TIMEOUT) bits, wrap-free.

Reset
REQ-032 SHALL, while rst=1, force state IDLE, counters 0, m_din 0, m_opcode 0, m_ptr_set 0, m_vin 0, res_data 0, res_v 0, err 0.
REQ-033 SHALL, on rst mid-transaction, abandon it without further m_vin pulses; cfg_rdy follows REQ-018 after reset.

Verification (PERIOD=100, TIMEOUT=50, BYTES_W=3, BYTES_R=2, DEV_ADDR=8'h48, REG_PTR=8'h05)
REQ-034 SHALL cover poll: enable=1 with master model returning 16'h1A2B -> m_vin with ptr_set=1, m_din=24'h050000, then opcode=1 read, res_data=16'h1A2B, single res_v.
REQ-035 SHALL cover cfg: cfg_v with cfg_data=24'h01_60_A0 in IDLE -> m_din=24'h0160A0, opcode=0, ptr_set=0, no res_v.
REQ-036 SHALL cover collision: cfg_v on the timer==99 cycle -> CFG transaction first, poll only after next 100 clocks.
REQ-037 SHALL cover timeout: m_busy held 0 after m_vin -> err pulse exactly 50 cycles after entry, state IDLE, res_data unchanged.
REQ-038 SHALL cover reset: rst asserted in RD_WAIT -> all outputs reset next cycle, no m_vin until re-enabled and 100 clocks elapse.
REQ-039 SHALL cover disable: enable dropped during PTR_WAIT -> read completes, res_v pulses, FSM returns to IDLE.
